// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Bundle of request/release/grant signals between the requesters and the
// rr_arbiter.
//   req           [PORTS]          request vector, bit i = requester i
//   ack           [PORTS]          release strobe, only the granted bit matters
//   grant         [PORTS]          one-hot grant, zero when idle
//   grant_valid   [1]              a grant is currently held
//   grant_encoded [$clog2(PORTS)]  binary index of the granted requester
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int PORTS = 4
);
  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0] req;
  logic [PORTS-1:0] ack;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_encoded;

  modport master (
    output req,
    output ack,
    input  grant,
    input  grant_valid,
    input  grant_encoded
  );

  modport slave (
    input  req,
    input  ack,
    output grant,
    output grant_valid,
    output grant_encoded
  );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// N-way arbiter granting one requester at a time to a shared resource.
// Round-robin or fixed priority; the grant is registered and held until the
// owner releases it (ack strobe, or dropping its request).
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of rr_arbiter_if (req/ack in, grant/valid/encoded out)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no grant held; any request is granted on the next edge
// ST_OWNED | one requester owns the resource until it releases
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 1,
  parameter int LSB_HIGH_PRIORITY    = 1,
  parameter int BLOCK_UNTIL_ACK      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           r_state;
  logic [PORTS-1:0] r_grant;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_enc;
  logic [IDX_W-1:0] r_last_idx;

  logic [PORTS-1:0] w_mask;
  logic [PORTS-1:0] w_req_masked;
  logic [IDX_W-1:0] w_masked_idx;
  logic [IDX_W-1:0] w_unmasked_idx;
  logic [IDX_W-1:0] w_win_idx;
  logic [PORTS-1:0] w_win_onehot;
  logic             w_any_req;
  logic             w_any_masked;
  logic             w_release;

  // Highest-priority set bit. The loop runs from lowest to highest priority
  // so the last hit is the winner.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Bits strictly after the last winner in scan order.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (LSB_HIGH_PRIORITY != 0) w_mask[i] = (i > int'(r_last_idx));
      else                        w_mask[i] = (i < int'(r_last_idx));
    end
  end

  assign w_req_masked   = bus.req & w_mask;
  assign w_any_req      = |bus.req;
  assign w_any_masked   = |w_req_masked;
  assign w_masked_idx   = prio_idx(w_req_masked);
  assign w_unmasked_idx = prio_idx(bus.req);

  // Round-robin falls back to the unmasked encoder when nothing lies after
  // the last winner; that wrap also lets a sole requester win again.
  assign w_win_idx    = ((ARB_TYPE_ROUND_ROBIN != 0) && w_any_masked) ? w_masked_idx
                                                                      : w_unmasked_idx;
  assign w_win_onehot = {{(PORTS-1){1'b0}}, 1'b1} << w_win_idx;

  assign w_release = (BLOCK_UNTIL_ACK != 0) ? bus.ack[r_grant_enc]
                                            : ~bus.req[r_grant_enc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_enc   <= '0;
      // Seed so the first round-robin pick matches the fixed-priority pick.
      r_last_idx    <= (LSB_HIGH_PRIORITY != 0) ? IDX_W'(PORTS - 1) : '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state       <= ST_OWNED;
            r_grant       <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_enc   <= w_win_idx;
            r_last_idx    <= w_win_idx;
          end
        end
        ST_OWNED: begin
          // Release and re-arbitration share one edge: no idle gap on handover.
          if (w_release) begin
            if (w_any_req) begin
              r_grant       <= w_win_onehot;
              r_grant_valid <= 1'b1;
              r_grant_enc   <= w_win_idx;
              r_last_idx    <= w_win_idx;
            end else begin
              r_state       <= ST_IDLE;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_grant_enc   <= '0;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_enc   <= '0;
        end
      endcase
    end
  end

  assign bus.grant         = r_grant;
  assign bus.grant_valid   = r_grant_valid;
  assign bus.grant_encoded = r_grant_enc;

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Three arbiter configurations side by side, sharing clock and reset:
//   d0: round-robin, index 0 highest, hold until ack
//   d1: fixed priority, index 0 highest, hold until ack
//   d2: round-robin, index 3 highest, hold while owner's req is high
// A reference model tracks owner and last winner per instance and picks
// winners by a circular scan over the request bits.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;
  localparam int P = 4;
  localparam int ND = 3;

  logic clk;
  logic rst_n;

  logic [P-1:0] req_v [ND];
  logic [P-1:0] ack_v [ND];
  logic [P-1:0] gnt_v [ND];
  logic         val_v [ND];
  logic [1:0]   enc_v [ND];

  rr_arbiter_if #(.PORTS(P)) if0 ();
  rr_arbiter_if #(.PORTS(P)) if1 ();
  rr_arbiter_if #(.PORTS(P)) if2 ();

  assign if0.req = req_v[0];
  assign if0.ack = ack_v[0];
  assign if1.req = req_v[1];
  assign if1.ack = ack_v[1];
  assign if2.req = req_v[2];
  assign if2.ack = ack_v[2];
  assign gnt_v[0] = if0.grant;
  assign val_v[0] = if0.grant_valid;
  assign enc_v[0] = if0.grant_encoded;
  assign gnt_v[1] = if1.grant;
  assign val_v[1] = if1.grant_valid;
  assign enc_v[1] = if1.grant_encoded;
  assign gnt_v[2] = if2.grant;
  assign val_v[2] = if2.grant_valid;
  assign enc_v[2] = if2.grant_encoded;

  rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .BLOCK_UNTIL_ACK(1))
    u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .BLOCK_UNTIL_ACK(1))
    u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  rr_arbiter #(.PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(0), .BLOCK_UNTIL_ACK(0))
    u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cfg_rr  [ND] = '{1, 0, 1};
  int cfg_lsb [ND] = '{1, 1, 0};
  int cfg_bua [ND] = '{1, 1, 0};

  int m_own  [ND];
  int m_last [ND];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [P-1:0] onehot(input int idx);
    logic [P-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Circular scan starting just after the last winner (round-robin), or a
  // plain priority scan (fixed); first set bit wins.
  function automatic int pick(input int d, input logic [P-1:0] r);
    int idx;
    for (int k = 0; k < P; k++) begin
      if (cfg_rr[d] != 0)
        idx = (cfg_lsb[d] != 0) ? (m_last[d] + 1 + k) % P : (m_last[d] - 1 - k + 2 * P) % P;
      else
        idx = (cfg_lsb[d] != 0) ? k : P - 1 - k;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_own[d]  = -1;
      m_last[d] = (cfg_lsb[d] != 0) ? P - 1 : 0;
    end
  endtask

  task automatic model_edge();
    int w;
    logic rel;
    for (int d = 0; d < ND; d++) begin
      if (m_own[d] < 0) rel = 1'b1;
      else if (cfg_bua[d] != 0) rel = ack_v[d][m_own[d]];
      else rel = !req_v[d][m_own[d]];
      if (rel) begin
        w = pick(d, req_v[d]);
        m_own[d] = w;
        if (w >= 0) m_last[d] = w;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [P-1:0] eg;
    logic         ev;
    logic [1:0]   ee;
    for (int d = 0; d < ND; d++) begin
      eg = onehot(m_own[d]);
      ev = (m_own[d] >= 0);
      ee = (m_own[d] >= 0) ? 2'(m_own[d]) : 2'd0;
      n_vec++;
      assert (gnt_v[d] === eg) else begin
        n_err++;
        $error("FAIL %s d%0d grant observed=%b expected=%b", tag, d, gnt_v[d], eg);
      end
      n_vec++;
      assert (val_v[d] === ev) else begin
        n_err++;
        $error("FAIL %s d%0d grant_valid observed=%b expected=%b", tag, d, val_v[d], ev);
      end
      n_vec++;
      assert (enc_v[d] === ee) else begin
        n_err++;
        $error("FAIL %s d%0d grant_encoded observed=%0d expected=%0d", tag, d, enc_v[d], ee);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_all(input logic [P-1:0] r, input logic [P-1:0] a);
    for (int d = 0; d < ND; d++) begin
      req_v[d] = r;
      ack_v[d] = a;
    end
  endtask

  task automatic ack_owners();
    for (int d = 0; d < ND; d++) ack_v[d] = onehot(m_own[d]);
  endtask

  initial begin
    set_all(4'b0000, 4'b0000);
    do_reset("reset");

    // Single requester granted after one edge and held without ack.
    set_all(4'b0100, 4'b0000);
    step("req0100");
    for (int i = 0; i < 5; i++) step("hold0100");

    // All requesting, owner acked every grant.
    do_reset("reset2");
    set_all(4'b1111, 4'b0000);
    step("all_first");
    for (int i = 0; i < 6; i++) begin
      ack_owners();
      step("all_rotate");
    end

    // Two requesters; fixed priority keeps re-granting index 1.
    set_all(4'b1010, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      ack_owners();
      step("req1010");
    end

    // Owner drops req with no ack, then wrong-bit ack, then correct ack.
    do_reset("reset3");
    set_all(4'b0010, 4'b0000);
    step("own1");
    set_all(4'b0000, 4'b0000);
    step("drop_noack");
    step("drop_noack2");
    set_all(4'b0101, 4'b0001);
    step("wrong_ack");
    ack_v[0] = 4'b0010;
    ack_v[1] = 4'b0010;
    ack_v[2] = 4'b0000;
    step("right_ack");

    // Owner 2 holds req for 3 cycles with ack toggling, then drops with req[0] up.
    do_reset("reset4");
    set_all(4'b0100, 4'b0000);
    step("own2");
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < ND; d++) ack_v[d] = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      req_v[2] = 4'b0100;
      req_v[0] = 4'b0100;
      req_v[1] = 4'b0100;
      step("hold_toggle");
    end
    set_all(4'b0001, 4'b0000);
    step("drop_handover");

    // Reset in mid-ownership, then full request.
    set_all(4'b1111, 4'b0000);
    step("pre_rst");
    step("pre_rst2");
    do_reset("async_rst");
    step("post_rst");

    // Random traffic, acks biased toward the current owner.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < ND; d++) begin
        req_v[d] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) ack_v[d] = onehot(m_own[d]);
        else ack_v[d] = 4'($urandom_range(0, 15));
      end
      step("random");
      if (i % 97 == 50) do_reset("random_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
